// File: rtl/exec_ctrl.sv
// Instruction sequencer: captures one instruction, reads operands, drives an external ALU, writes back to W or the file.
// Define EXEC_DBG_PORT_EN to add a combinational file read port (dbg_addr/dbg_data).
module exec_ctrl (
`ifdef EXEC_DBG_PORT_EN
    input  logic [3:0]  dbg_addr,
    output logic [7:0]  dbg_data,
`endif
    input  logic        clk2,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [23:0] instr,
    output logic [3:0]  alu_inst,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_bit,
    output logic        alu_we,
    input  logic [7:0]  alu_result,
    input  logic        alu_carry,
    output logic [7:0]  w_reg,
    output logic        flag_z,
    output logic        flag_c,
    output logic        done
);

    // state | meaning
    // IDLE  | waiting for an instruction, instr_ready high
    // READ  | operands latched from W/literal and file[addr]
    // EXEC  | ALU driven, result and carry registered
    // WB    | result written to W or file, flags updated, done pulsed
    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    // Bit n set means op n updates that flag.
    localparam logic [15:0] C_OPS = 16'h810C;
    localparam logic [15:0] Z_OPS = 16'h14FD;

    state_t      state_q, state_d;
    logic [1:0]  rel_sync_q;
    logic        accept;

    logic [3:0]  op_q;
    logic        dest_q;
    logic        lit_sel_q;
    logic [2:0]  bit_q;
    logic [3:0]  addr_q;
    logic [7:0]  lit_q;

    logic [7:0]  a_q, b_q, res_q;
    logic        carry_q;
    logic [7:0]  file_q [16];
    logic [7:0]  wb_val;

    logic        unused_rsvd;
    assign unused_rsvd = ^instr[14:12];

    // Accepts are held off until the release has crossed two flops.
    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) rel_sync_q <= 2'b00;
        else        rel_sync_q <= {rel_sync_q[0], 1'b1};
    end

    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        accept      = 1'b0;
        alu_we      = 1'b0;
        done        = 1'b0;
        alu_inst    = 4'd0;
        alu_a       = 8'h00;
        alu_b       = 8'h00;
        alu_bit     = 3'd0;
        case (state_q)
            IDLE: begin
                instr_ready = rel_sync_q[1] | ~reset;
                accept      = instr_valid & rel_sync_q[1];
                if (accept) state_d = READ;
            end
            READ: state_d = EXEC;
            EXEC: begin
                alu_we   = 1'b1;
                alu_inst = op_q;
                alu_a    = a_q;
                alu_b    = b_q;
                alu_bit  = bit_q;
                state_d  = WB;
            end
            WB: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            op_q      <= 4'd0;
            dest_q    <= 1'b0;
            lit_sel_q <= 1'b0;
            bit_q     <= 3'd0;
            addr_q    <= 4'd0;
            lit_q     <= 8'h00;
            a_q       <= 8'h00;
            b_q       <= 8'h00;
            res_q     <= 8'h00;
            carry_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q      <= instr[23:20];
                dest_q    <= instr[19];
                lit_sel_q <= instr[18];
                bit_q     <= instr[17:15];
                addr_q    <= instr[11:8];
                lit_q     <= instr[7:0];
            end
            if (state_q == READ) begin
                a_q <= lit_sel_q ? lit_q : w_reg;
                b_q <= file_q[addr_q];
            end
            if (state_q == EXEC) begin
                res_q   <= alu_result;
                carry_q <= alu_carry;
            end
        end
    end

    // Op 9 is a clear: the ALU output is not trusted for it.
    assign wb_val = (op_q == 4'd9) ? 8'h00 : res_q;

    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            w_reg  <= 8'h00;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            for (int i = 0; i < 16; i++) file_q[i] <= 8'h00;
        end else if (state_q == WB) begin
            if (dest_q) file_q[addr_q] <= wb_val;
            else        w_reg          <= wb_val;
            if (C_OPS[op_q]) flag_c <= carry_q;
            if (Z_OPS[op_q]) flag_z <= (wb_val == 8'h00);
        end
    end

`ifdef EXEC_DBG_PORT_EN
    assign dbg_data = file_q[dbg_addr];
`endif

endmodule

// File: doc/exec_ctrl.md
EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 clk2  input  1  sole clock; all state changes on its rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 instr_valid  input  1  instruction word present on instr.
REQ-004 instr_ready  output  1  controller can accept an instruction.
REQ-005 instr  input  24  [23:20] op, [19] dest (0=W, 1=file), [18] lit_sel, [17:15] bit, [14:12] reserved, [11:8] file addr, [7:0] literal.
REQ-006 alu_inst  output  4  opcode driven to the ALU.
REQ-007 alu_a  output  8  ALU a operand: literal if lit_sel=1, else W.
REQ-008 alu_b  output  8  ALU b operand: file[addr].
REQ-009 alu_bit  output  3  bit number for bit-set and bit-clear ops.
REQ-010 alu_we  output  1  high only in EXEC.
REQ-011 alu_result  input  8  ALU result.
REQ-012 alu_carry  input  1  ALU carry/borrow (result bit 8).
REQ-013 w_reg  output  8  working register.
REQ-014 flag_z, flag_c  output  1 each  zero and carry status.
REQ-015 done  output  1  one-cycle pulse in WB.

Function
REQ-016 The controller SHALL contain 16 x 8-bit file registers, W, and the flags.
REQ-017 FSM states are IDLE, READ, EXEC and WB. IDLE->READ on instr_valid&instr_ready, then READ->EXEC->WB->IDLE unconditionally.
REQ-018 instr_ready SHALL be 1 only in IDLE.
REQ-019 On accept, instr SHALL be captured. instr_valid and instr changes SHALL be ignored outside IDLE.
REQ-020 READ SHALL register file[addr] into the b-operand register, and W or literal into the a-operand register.
REQ-021 EXEC SHALL drive alu_inst/alu_a/alu_b/alu_bit from the captured values and register alu_result and alu_carry at the end of the cycle.
REQ-022 WB SHALL write the registered result to W (dest=0) or file[addr] (dest=1), update the flags, and pulse done.
REQ-023 Latency: accept edge + 3 cycles. Result is visible in W or file the cycle after WB. The next accept is possible one cycle after WB.
REQ-024 flag_c SHALL update only for ops 2, 3, 8 and 15; it is raw alu_carry, so op 3 gives borrow=1 when a>b.
REQ-025 flag_z SHALL update for ops 0, 2, 3, 4, 5, 6, 7, 10 and 12: 1 iff the 8-bit result is 0x00. Other ops leave it unchanged.
REQ-026 Op 9 SHALL write 0x00 to the destination without changing flags.
REQ-027 Reserved bits [14:12] SHALL be ignored. Addr is full 4-bit, so there is no wrap beyond 15.
REQ-028 Results SHALL be truncated to 8 bits; inc of 0xFF gives 0x00 and dec of 0x00 gives 0xFF.
REQ-029 When dest=1 and the next instruction reads the same addr, it SHALL see the new value, because WB precedes its READ.

Reset
REQ-030 While reset=0: state=IDLE, instr_ready=1, W=0x00, all file registers 0x00, flag_z=0, flag_c=0, done=0, alu_we=0, alu_inst=0, alu_a=0, alu_b=0, alu_bit=0.
REQ-031 Reset in READ, EXEC or WB SHALL abort the instruction, with no writeback and no done pulse.
REQ-032 Release SHALL be synchronised so that the first accept occurs no earlier than the second rising edge after deassertion.

Configuration
REQ-033 With EXEC_DBG_PORT_EN defined, the module SHALL add ports dbg_addr (input, 4 bits) and dbg_data (output, 8 bits), where dbg_data = file[dbg_addr] combinationally with no side effects.
REQ-034 Without EXEC_DBG_PORT_EN, those ports SHALL be absent and the behaviour SHALL be otherwise identical.

Verification
REQ-035 Assert reset for 2 cycles, then release -> W=0x00, flags 0, instr_ready=1, all file registers 0.
REQ-036 op1, lit_sel=1, dest=0, literal 0x5A -> done 3 cycles after accept, W=0x5A, flag_z unchanged (0).
REQ-037 Load W=0xF0 and file[3]=0x20, then op2, dest=1, addr 3 -> file[3]=0x10, flag_c=1, flag_z=0.
REQ-038 W=0x05 and file[2]=0x05, then op3, dest=0, addr 2 -> W=0x00, flag_z=1, flag_c=0.
REQ-039 file[1]=0x00, then op13, bit 7, dest=1 -> file[1]=0x80, flags unchanged; then op14, bit 7 -> 0x00.
REQ-040 Accept a write of 0x33 to file[4] and drop reset during EXEC -> file[4]=0x00, no done, instr_ready=1 after release.
